// File: rtl/fxp_sqrt_engine.sv
// Iterative restoring square root of a signed fixed-point operand, one result
// bit per cycle, behind an ap_start/ap_done/ap_idle/ap_ready block handshake.
module fxp_sqrt_engine #(
  parameter int BIT_WIDTH = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ap_start,
  input  logic [BIT_WIDTH-1:0] in_r,
  output logic                 ap_idle,
  output logic                 ap_ready,
  output logic                 ap_done,
  output logic [BIT_WIDTH-1:0] ap_return,
  output logic                 neg_err
);

  localparam int RAD_W = BIT_WIDTH + FRAC_BITS;
  localparam int N     = RAD_W / 2;
  localparam int REM_W = N + 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [RAD_W-1:0]     rad_reg, rad_next;
  logic [REM_W-1:0]     rem_reg, rem_next;
  logic [N-1:0]         root_reg, root_next;
  logic                 done_reg, done_next;
  logic [BIT_WIDTH-1:0] ret_reg, ret_next;
  logic                 neg_reg, neg_next;

  logic [REM_W-1:0]     rem_shift;
  logic [REM_W-1:0]     trial;
  logic [REM_W-1:0]     rem_diff;
  logic                 take;
  logic [N-1:0]         root_step;
  logic [BIT_WIDTH-1:0] root_ext;
  logic                 unused_rem_hi;

  // One restoring step: bring down the next radicand bit pair, try {root,01}.
  assign rem_shift = {rem_reg[N-1:0], rad_reg[RAD_W-1 -: 2]};
  assign trial     = {root_reg, 2'b01};
  assign rem_diff  = rem_shift - trial;
  assign take      = (rem_shift >= trial);
  assign root_step = {root_reg[N-2:0], take};

  // The top remainder bits only become non-zero on the final step and are
  // never shifted out again, so they feed nothing.
  assign unused_rem_hi = |rem_reg[REM_W-1:N];

  genvar gi;
  generate
    for (gi = 0; gi < BIT_WIDTH; gi++) begin : g_ext
      if (gi < N) begin : g_bit
        assign root_ext[gi] = root_step[gi];
      end else begin : g_pad
        assign root_ext[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      rad_reg   <= '0;
      rem_reg   <= '0;
      root_reg  <= '0;
      done_reg  <= 1'b0;
      ret_reg   <= '0;
      neg_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rad_reg   <= rad_next;
      rem_reg   <= rem_next;
      root_reg  <= root_next;
      done_reg  <= done_next;
      ret_reg   <= ret_next;
      neg_reg   <= neg_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rad_next   = rad_reg;
    rem_next   = rem_reg;
    root_next  = root_reg;
    done_next  = 1'b0;
    ret_next   = ret_reg;
    neg_next   = neg_reg;

    case (state_reg)
      S_IDLE: begin
        if (ap_start) begin
          rad_next  = {in_r, {FRAC_BITS{1'b0}}};
          rem_next  = '0;
          root_next = '0;
          cnt_next  = '0;
          if (in_r[BIT_WIDTH-1]) begin
            // Negative operands skip the iterations entirely.
            state_next = S_DONE;
            done_next  = 1'b1;
            ret_next   = '0;
            neg_next   = 1'b1;
          end else begin
            state_next = S_CALC;
          end
        end
      end

      S_CALC: begin
        rad_next  = {rad_reg[RAD_W-3:0], 2'b00};
        rem_next  = take ? rem_diff : rem_shift;
        root_next = root_step;
        cnt_next  = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_CNT) begin
          state_next = S_DONE;
          done_next  = 1'b1;
          ret_next   = root_ext;
          neg_next   = 1'b0;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign ap_idle   = (state_reg == S_IDLE);
  assign ap_ready  = ap_start & ap_idle;
  assign ap_done   = done_reg;
  assign ap_return = ret_reg;
  assign neg_err   = neg_reg;

endmodule

// File: tb/tb_fxp_sqrt_engine.sv
// Bench for fxp_sqrt_engine: cycle-level behavioural model checked every cycle,
// directed handshake/reset scenarios, then a randomized operand sweep.
module tb_fxp_sqrt_engine;

  localparam int BW = 32;
  localparam int FB = 16;
  localparam int N  = (BW + FB) / 2;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          ap_start = 1'b0;
  logic [BW-1:0] in_r     = '0;
  logic          ap_idle;
  logic          ap_ready;
  logic          ap_done;
  logic [BW-1:0] ap_return;
  logic          neg_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fxp_sqrt_engine #(.BIT_WIDTH(BW), .FRAC_BITS(FB)) dut (
    .clk      (clk),
    .reset    (reset),
    .ap_start (ap_start),
    .in_r     (in_r),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .ap_done  (ap_done),
    .ap_return(ap_return),
    .neg_err  (neg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Reference: floor(sqrt(in_r * 2^FB)) from real arithmetic, nudged to exact.
  function automatic logic [BW-1:0] ref_sqrt(input logic [BW-1:0] v);
    longint unsigned x;
    longint unsigned r;
    x = longint'(v) << FB;
    r = longint'($floor($sqrt(real'(x))));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return BW'(r);
  endfunction

  // Behavioural model state: busy window, pending and held results.
  bit            m_busy = 1'b0;
  int            m_done_at = 0;
  logic [BW-1:0] m_ret = '0;
  logic          m_neg = 1'b0;
  logic [BW-1:0] p_ret;
  logic          p_neg;
  bit            exp_idle;
  bit            exp_done;

  always @(negedge clk) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_ret  = '0;
      m_neg  = 1'b0;
      check("rst_done", 32'(ap_done), 32'd0);
      check("rst_idle", 32'(ap_idle), 32'd1);
      check("rst_ret", ap_return, 32'd0);
      check("rst_neg", 32'(neg_err), 32'd0);
    end else begin
      exp_idle = !m_busy;
      exp_done = m_busy && (cyc == m_done_at);
      if (exp_done) begin
        m_ret = p_ret;
        m_neg = p_neg;
      end
      check("idle", 32'(ap_idle), 32'(exp_idle));
      check("ready", 32'(ap_ready), 32'(exp_idle & ap_start));
      check("done", 32'(ap_done), 32'(exp_done));
      check("ret", ap_return, m_ret);
      check("neg", 32'(neg_err), 32'(m_neg));
      if (exp_done) m_busy = 1'b0;
      if (exp_idle && ap_start) begin
        m_busy = 1'b1;
        if (in_r[BW-1]) begin
          m_done_at = cyc + 1;
          p_ret = '0;
          p_neg = 1'b1;
        end else begin
          m_done_at = cyc + N + 1;
          p_ret = ref_sqrt(in_r);
          p_neg = 1'b0;
        end
      end
    end
  end

  // One request with literal expectations on result and latency.
  task automatic do_op(input logic [BW-1:0] v, input logic [BW-1:0] er,
                       input logic en, input int el);
    int t0;
    bit seen;
    @(posedge clk); #1;
    ap_start = 1'b1;
    in_r     = v;
    @(negedge clk);
    t0 = cyc;
    check("accept_ready", 32'(ap_ready), 32'd1);
    @(posedge clk); #1;
    ap_start = 1'b0;
    in_r     = $urandom;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (ap_done) begin
        seen = 1'b1;
        check("op_latency", 32'(cyc - t0), 32'(el));
        check("op_ret", ap_return, er);
        check("op_neg", 32'(neg_err), 32'(en));
      end
    end
    if (!seen) check("op_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [BW-1:0] rand_operand();
    logic [BW-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = $urandom | 32'h8000_0000;
      1:       v = BW'($urandom_range(0, 255));
      2:       v = 32'h7FFF_FFFF - BW'($urandom_range(0, 255));
      3:       v = BW'($urandom_range(0, 32'h000F_FFFF));
      default: v = $urandom & 32'h7FFF_FFFF;
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  int            dcnt;
  int            dk[3];
  logic [BW-1:0] dr[3];
  logic          dn[3];

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_idle", 32'(ap_idle), 32'd1);
    check("reset_ret", ap_return, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Pin the model itself against hand-computed values.
    check("model_4", ref_sqrt(32'h0004_0000), 32'h0002_0000);
    check("model_2", ref_sqrt(32'h0002_0000), 32'h0001_6A09);
    check("model_max", ref_sqrt(32'h7FFF_FFFF), 32'h00B5_04F3);

    do_op(32'h0004_0000, 32'h0002_0000, 1'b0, N + 1);
    do_op(32'h0002_0000, 32'h0001_6A09, 1'b0, N + 1);
    do_op(32'h0000_0001, 32'h0000_0100, 1'b0, N + 1);
    do_op(32'h0000_0000, 32'h0000_0000, 1'b0, N + 1);
    do_op(32'h7FFF_FFFF, 32'h00B5_04F3, 1'b0, N + 1);
    do_op(32'hFFFF_0000, 32'h0000_0000, 1'b1, 1);

    // Back-to-back with ap_start held; in_r scrambled between accepts.
    dcnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      ap_start = (k <= 52);
      in_r = (k == 0) ? 32'h0004_0000 : (k == 26) ? 32'h0002_0000 :
             (k == 52) ? 32'hFFFF_0000 : $urandom;
      @(negedge clk);
      if (ap_done) begin
        if (dcnt < 3) begin
          dk[dcnt] = k;
          dr[dcnt] = ap_return;
          dn[dcnt] = neg_err;
        end
        dcnt++;
      end
    end
    check("b2b_count", 32'(dcnt), 32'd3);
    if (dcnt >= 3) begin
      check("b2b_t0", 32'(dk[0]), 32'd25);
      check("b2b_t1", 32'(dk[1]), 32'd51);
      check("b2b_t2", 32'(dk[2]), 32'd53);
      check("b2b_r0", dr[0], 32'h0002_0000);
      check("b2b_r1", dr[1], 32'h0001_6A09);
      check("b2b_r2", dr[2], 32'h0000_0000);
      check("b2b_n2", 32'(dn[2]), 32'd1);
    end

    // Reset in the middle of CALC: outputs clear at once, no late ap_done.
    do_op(32'h0002_0000, 32'h0001_6A09, 1'b0, N + 1);
    @(posedge clk); #1;
    ap_start = 1'b1;
    in_r     = 32'h0004_0000;
    @(posedge clk); #1;
    ap_start = 1'b0;
    repeat (8) @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_done", 32'(ap_done), 32'd0);
    check("mid_rst_ret", ap_return, 32'd0);
    check("mid_rst_neg", 32'(neg_err), 32'd0);
    check("mid_rst_idle", 32'(ap_idle), 32'd1);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ap_done) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    do_op(32'h0004_0000, 32'h0002_0000, 1'b0, N + 1);

    // Randomized sweep; the per-cycle model does all checking here.
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk); #1;
      reset    = ($urandom_range(0, 2999) != 0);
      ap_start = ($urandom_range(0, 3) != 0);
      in_r     = rand_operand();
    end
    @(posedge clk); #1;
    reset    = 1'b1;
    ap_start = 1'b0;
    repeat (N + 5) @(posedge clk);
    @(negedge clk);
    check("final_idle", 32'(ap_idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
